// File: rtl/avalon_pio_input.sv
// Avalon-MM PIO input port: synchronizes and debounces WIDTH external pins,
// then exposes the clean value, an edge-capture register and a maskable level irq.
module avalon_pio_input #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    input  logic [WIDTH-1:0] pio_in,
    output logic             irq
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ADDR_DATA        = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK    = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAPT   = 2'd2;
    localparam logic [1:0] ADDR_EDGE_SELECT = 2'd3;

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] debounced_d;
    logic [WIDTH-1:0] deb_next;
    logic [CNT_W-1:0] deb_cnt  [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];

    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_select;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] w1c_clear;
    logic [WIDTH-1:0] wr_bits;
    logic [31:0]      read_value;

    logic wr_mask;
    logic wr_capture;
    logic wr_select;

    // Upper writedata bits beyond WIDTH are deliberately ignored.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata;

    assign wr_bits    = avs_writedata[WIDTH-1:0];
    assign wr_mask    = avs_write && (avs_address == ADDR_IRQ_MASK);
    assign wr_capture = avs_write && (avs_address == ADDR_EDGE_CAPT);
    assign wr_select  = avs_write && (avs_address == ADDR_EDGE_SELECT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= pio_in;
            sync_out  <= sync_meta;
        end
    end

    // A bit flips only once its counter has seen DEBOUNCE_CYCLES mismatches in a row.
    always_comb begin
        deb_next = debounced;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync_out[i] != debounced[i]) begin
                if (deb_cnt[i] == CNT_LAST) begin
                    deb_next[i] = sync_out[i];
                end else begin
                    cnt_next[i] = deb_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounced   <= '0;
            debounced_d <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            debounced   <= deb_next;
            debounced_d <= debounced;
            for (int i = 0; i < WIDTH; i++) begin
                deb_cnt[i] <= cnt_next[i];
            end
        end
    end

    // EDGE_SELECT bit 0 picks rising edges, bit 1 picks falling edges.
    always_comb begin
        edge_set  = (debounced & ~debounced_d & ~edge_select) |
                    (~debounced & debounced_d & edge_select);
        w1c_clear = wr_capture ? wr_bits : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_select  <= '0;
            edge_capture <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr_mask) begin
                irq_mask <= wr_bits;
            end
            if (wr_select) begin
                edge_select <= wr_bits;
            end
            edge_capture <= (edge_capture & ~w1c_clear) | edge_set;
            irq          <= |(edge_capture & irq_mask);
        end
    end

    always_comb begin
        read_value = '0;
        case (avs_address)
            ADDR_DATA:        read_value = 32'(debounced);
            ADDR_IRQ_MASK:    read_value = 32'(irq_mask);
            ADDR_EDGE_CAPT:   read_value = 32'(edge_capture);
            ADDR_EDGE_SELECT: read_value = 32'(edge_select);
            default:          read_value = '0;
        endcase
    end

    // Registers are sampled before this cycle's writes land, so reads see old contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= read_value;
        end
    end

endmodule

// File: tb/tb_avalon_pio_input.sv
// Self-checking bench for avalon_pio_input: directed scenarios plus random traffic,
// all compared against a window-based behavioural model of the debounced port.
module tb_avalon_pio_input;

    localparam int WIDTH           = 4;
    localparam int DEBOUNCE_CYCLES = 4;

    logic        clk;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [3:0]  pio_in;
    logic        irq;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [3:0]  curPins;
    logic [31:0] rdVal;

    avalon_pio_input #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .pio_in(pio_in),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pins reach the debouncer two edges late, and a debounced bit
    // flips when every one of the last DEBOUNCE_CYCLES synced samples disagrees with it.
    logic [3:0]  mPinQ [$];
    logic [3:0]  mWin  [$];
    logic [3:0]  mDeb, mDebPrev, mMask, mSel, mCap;
    logic [3:0]  nDeb, nCap, edgeSet, clrBits, synced;
    logic        mIrq, nIrq, allDiffer;
    logic [31:0] mRdata, nRdata;

    function automatic logic [31:0] mRegVal(input logic [1:0] a);
        case (a)
            2'd0:    return {28'b0, mDeb};
            2'd1:    return {28'b0, mMask};
            2'd2:    return {28'b0, mCap};
            default: return {28'b0, mSel};
        endcase
    endfunction

    task automatic modelReset();
        mPinQ = {};
        mPinQ.push_back(4'b0);
        mPinQ.push_back(4'b0);
        mWin = {};
        repeat (DEBOUNCE_CYCLES) mWin.push_back(4'b0);
        mDeb     = '0;
        mDebPrev = '0;
        mMask    = '0;
        mSel     = '0;
        mCap     = '0;
        mIrq     = 1'b0;
        mRdata   = '0;
    endtask

    task automatic modelStep();
        nRdata  = avs_read ? mRegVal(avs_address) : mRdata;
        nIrq    = |(mCap & mMask);
        edgeSet = (mDeb & ~mDebPrev & ~mSel) | (~mDeb & mDebPrev & mSel);
        clrBits = (avs_write && avs_address == 2'd2) ? avs_writedata[3:0] : 4'b0;
        nCap    = (mCap & ~clrBits) | edgeSet;
        mPinQ.push_back(pio_in);
        synced = mPinQ.pop_front();
        mWin.push_back(synced);
        void'(mWin.pop_front());
        for (int b = 0; b < 4; b++) begin
            allDiffer = 1'b1;
            foreach (mWin[k]) begin
                if (mWin[k][b] == mDeb[b]) allDiffer = 1'b0;
            end
            nDeb[b] = allDiffer ? ~mDeb[b] : mDeb[b];
        end
        if (avs_write && avs_address == 2'd1) mMask = avs_writedata[3:0];
        if (avs_write && avs_address == 2'd3) mSel  = avs_writedata[3:0];
        mDebPrev = mDeb;
        mDeb     = nDeb;
        mCap     = nCap;
        mIrq     = nIrq;
        mRdata   = nRdata;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) modelReset();
        else          modelStep();
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // One bus cycle: compare outputs against the model, then drive the next inputs.
    task automatic applyStimulus(input logic [3:0] pins, input logic rd, input logic wr,
                                 input logic [1:0] addr, input logic [31:0] wd);
        @(negedge clk);
        checkOutput("model irq", {31'b0, irq}, {31'b0, mIrq});
        checkOutput("model readdata", avs_readdata, mRdata);
        pio_in        = pins;
        avs_read      = rd;
        avs_write     = wr;
        avs_address   = addr;
        avs_writedata = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(curPins, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic setPins(input logic [3:0] p);
        curPins = p;
        applyStimulus(curPins, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        applyStimulus(curPins, 1'b1, 1'b0, addr, 32'h0);
        applyStimulus(curPins, 1'b0, 1'b0, 2'd0, 32'h0);
        data = avs_readdata;
    endtask

    task automatic writeReg(input logic [1:0] addr, input logic [31:0] wd);
        applyStimulus(curPins, 1'b0, 1'b1, addr, wd);
        applyStimulus(curPins, 1'b0, 1'b0, 2'd0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        pio_in        = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_address   = '0;
        avs_writedata = '0;
        curPins       = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        checkOutput("reset readdata", avs_readdata, 32'h0);
        checkOutput("reset irq", {31'b0, irq}, 32'h0);
        idle(3);

        // Clean rising edge on bit0: DATA read back shows the change at the 7th sample.
        curPins = 4'b0001;
        applyStimulus(curPins, 1'b1, 1'b0, 2'd0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(curPins, 1'b1, 1'b0, 2'd0, 32'h0);
            checkOutput($sformatf("debounce latency k=%0d", k), avs_readdata,
                        (k >= 7) ? 32'h1 : 32'h0);
        end
        idle(1);
        readReg(2'd2, rdVal);
        checkOutput("capture after rise", rdVal, 32'h1);
        writeReg(2'd2, 32'h1);
        readReg(2'd2, rdVal);
        checkOutput("capture cleared", rdVal, 32'h0);

        // Three-cycle glitch on bit1 must be discarded.
        setPins(4'b0011);
        idle(2);
        setPins(4'b0001);
        idle(10);
        readReg(2'd0, rdVal);
        checkOutput("glitch data", rdVal, 32'h1);
        readReg(2'd2, rdVal);
        checkOutput("glitch capture", rdVal, 32'h0);

        // Masked rising edge drives irq; W1C drops it.
        writeReg(2'd1, 32'h1);
        setPins(4'b0000);
        idle(10);
        readReg(2'd2, rdVal);
        checkOutput("falling ignored", rdVal, 32'h0);
        setPins(4'b0001);
        for (int k = 1; k <= 9; k++) begin
            idle(1);
            checkOutput($sformatf("irq timing k=%0d", k), {31'b0, irq},
                        (k >= 8) ? 32'h1 : 32'h0);
        end
        applyStimulus(curPins, 1'b0, 1'b1, 2'd2, 32'h1);
        idle(1);
        checkOutput("irq one cycle after clear", {31'b0, irq}, 32'h1);
        idle(1);
        checkOutput("irq low after clear", {31'b0, irq}, 32'h0);
        readReg(2'd2, rdVal);
        checkOutput("capture w1c", rdVal, 32'h0);

        // Falling-edge select on bit2.
        writeReg(2'd1, 32'h0);
        writeReg(2'd3, 32'h4);
        setPins(4'b0101);
        idle(7);
        setPins(4'b0001);
        idle(13);
        readReg(2'd2, rdVal);
        checkOutput("falling select capture", rdVal, 32'h4);
        readReg(2'd3, rdVal);
        checkOutput("edge select readback", rdVal, 32'h4);
        writeReg(2'd2, 32'hF);

        // W1C in the very cycle bit0 captures: set wins.
        setPins(4'b0000);
        idle(10);
        setPins(4'b0001);
        idle(5);
        applyStimulus(curPins, 1'b0, 1'b1, 2'd2, 32'h1);
        readReg(2'd2, rdVal);
        checkOutput("set beats clear", rdVal, 32'h1);

        // Asynchronous reset mid-count with irq high.
        writeReg(2'd1, 32'h1);
        idle(2);
        checkOutput("irq before reset", {31'b0, irq}, 32'h1);
        readReg(2'd2, rdVal);
        setPins(4'b1001);
        idle(3);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset readdata", avs_readdata, 32'h0);
        checkOutput("async reset irq", {31'b0, irq}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        writeReg(2'd1, 32'hFFFF_FFFF);
        readReg(2'd1, rdVal);
        checkOutput("mask width clip", rdVal, 32'hF);
        idle(8);
        readReg(2'd2, rdVal);
        checkOutput("rise after reset", rdVal, 32'h9);
        readReg(2'd0, rdVal);
        checkOutput("data after reset", rdVal, 32'h9);

        // Random traffic against the model.
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 5) == 0) curPins = 4'($urandom);
            applyStimulus(curPins, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                          $urandom);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/avalon_pio_input.md
AVALON_PIO_INPUT -- requirements
Module: avalon_pio_input

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of input pins (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a level change (>=1).
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port avs_address, input, 2: Avalon-MM word register select.
REQ-006 SHALL have port avs_read, input, 1: read strobe.
REQ-007 SHALL have port avs_write, input, 1: write strobe.
REQ-008 SHALL have port avs_writedata, input, 32: write data.
REQ-009 SHALL have port avs_readdata, output, 32: read data, registered.
REQ-010 SHALL have port pio_in, input, WIDTH: asynchronous external pins (buttons/switches).
REQ-011 SHALL have port irq, output, 1: level interrupt, active-high, registered.

Function
REQ-012 SHALL pass each pio_in bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL keep one debounced bit and one counter per input bit; counter width = clog2(DEBOUNCE_CYCLES)+1.
REQ-014 SHALL, when synced bit equals debounced bit, clear that bit's counter.
REQ-015 SHALL, when synced bit differs and counter == DEBOUNCE_CYCLES-1, load debounced <= synced and clear counter; otherwise increment counter.
REQ-016 SHALL therefore change a debounced bit only after DEBOUNCE_CYCLES consecutive mismatching synced samples; any glitch shorter than that is discarded.
REQ-017 SHALL map registers: 0 DATA (RO, debounced value), 1 IRQ_MASK (RW), 2 EDGE_CAPTURE (W1C), 3 EDGE_SELECT (RW; bit=0 rising, bit=1 falling).
REQ-018 SHALL zero-extend all WIDTH-bit registers to 32 bits on read; writes ignore bits >= WIDTH; writes to DATA have no effect.
REQ-019 SHALL return avs_readdata exactly one cycle after avs_read is sampled high (fixed read latency 1, no waitrequest); readdata holds its last value otherwise.
REQ-020 SHALL set EDGE_CAPTURE[i] on the cycle after debounced bit i transitions in the direction chosen by EDGE_SELECT[i].
REQ-021 SHALL clear EDGE_CAPTURE[i] when written with bit i = 1; bits written 0 unchanged.
REQ-022 SHALL give set priority over clear when a qualifying edge and a W1C hit the same bit in the same cycle.
REQ-023 SHALL drive irq <= |(EDGE_CAPTURE & IRQ_MASK), registered; one cycle after capture/mask change.
REQ-024 SHALL, on a read of DATA in the same cycle as a debounced update, return the pre-update value.
REQ-025 SHALL treat simultaneous avs_read and avs_write as both performed; read returns pre-write contents.

Reset
REQ-026 SHALL on reset_n low immediately clear synchronizers, debounced bits, counters, IRQ_MASK, EDGE_CAPTURE, EDGE_SELECT, avs_readdata and irq to 0.
REQ-027 SHALL, after reset release with a pin held high, treat the resulting 0->1 debounced transition as a rising edge.
REQ-028 SHALL abandon any partial debounce count when reset asserts mid-operation.

Verification (bench uses WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-029 SHALL check: pio_in 0000->0001 held -> DATA reads 0x1 with debounced change exactly 2+4 cycles after the edge; EDGE_CAPTURE=0x1.
REQ-030 SHALL check: pio_in[1] high for 3 cycles then low -> DATA stays 0x0, EDGE_CAPTURE stays 0x0.
REQ-031 SHALL check: IRQ_MASK=0x1, rising edge on bit0 -> irq high one cycle after capture; write 0x1 to addr 2 -> EDGE_CAPTURE=0, irq low next cycle.
REQ-032 SHALL check: EDGE_SELECT=0x4, bit2 pulses 0->1->0 (each held 8 cycles) -> only falling edge captured, EDGE_CAPTURE=0x4.
REQ-033 SHALL check: W1C to bit0 in the same cycle bit0 captures -> EDGE_CAPTURE[0] remains 1.
REQ-034 SHALL check: reset_n asserted with counters mid-count and irq high -> all outputs 0 asynchronously; write 0xFFFFFFFF to IRQ_MASK reads back 0x0000000F.
